// File: rtl/pipe_hazard_ctrl.sv
// Issue-stage hazard controller: load-use/RAW stall, taken-branch flush, forwarding selects, retire count.
// Stall/flush are same-cycle combinational; fwd selects are registered into the EX cycle. Define PIPE_FORWARD_EN for forwarding.
// Backpressure: stall_fetch/stall_iss hold upstream stages; flush beats stall; BOOT holds the pipe for BOOT_HOLD cycles.
module pipe_hazard_ctrl #(
    parameter int unsigned BOOT_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_iss,
    input  logic [4:0]  rs1_iss,
    input  logic [4:0]  rs2_iss,
    input  logic        uses_rs1_iss,
    input  logic        uses_rs2_iss,
    input  logic [4:0]  rd_iss,
    input  logic        wr_rd_iss,
    input  logic        is_load_iss,
    input  logic        branch_taken_ex,
    output logic        stall_fetch,
    output logic        stall_iss,
    output logic        bubble_ex,
    output logic        flush_iss,
    output logic [1:0]  fwd_rs1_sel,
    output logic [1:0]  fwd_rs2_sel,
    output logic        instr_retired,
    output logic [31:0] retire_count
);

    localparam int HW = (BOOT_HOLD < 2) ? 1 : $clog2(BOOT_HOLD + 1);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    typedef enum logic {BOOT, RUN} state_t;

    state_t      r_state;
    logic [HW-1:0] r_hold;
    slot_t       r_ex;
    slot_t       r_mem;
    slot_t       r_wb;
    logic [31:0] r_retire_count;

    logic        w_run;
    logic        w_flush;
    logic        w_hazard;
    logic        w_bubble;
    logic        w_hit1_ex;
    logic        w_hit2_ex;
    logic        w_hit1_mem;
    logic        w_hit2_mem;
    logic [31:0] w_retire_nxt;
    logic        w_unused;

    // x0 is hardwired and never a real producer, so it can never match.
    function automatic logic slot_hit(input slot_t s, input logic [4:0] rs, input logic use_rs,
                                      input logic vld);
        return vld && use_rs && (rs != 5'd0) && s.vld && s.wr && (s.rd == rs);
    endfunction

    assign w_hit1_ex  = slot_hit(r_ex,  rs1_iss, uses_rs1_iss, valid_iss);
    assign w_hit2_ex  = slot_hit(r_ex,  rs2_iss, uses_rs2_iss, valid_iss);
    assign w_hit1_mem = slot_hit(r_mem, rs1_iss, uses_rs1_iss, valid_iss);
    assign w_hit2_mem = slot_hit(r_mem, rs2_iss, uses_rs2_iss, valid_iss);

    assign w_run   = (r_state == RUN);
    assign w_flush = w_run && branch_taken_ex;

`ifdef PIPE_FORWARD_EN
    assign w_hazard = w_run && r_ex.ld && (w_hit1_ex || w_hit2_ex);
    assign w_unused = ^{r_wb.rd, r_wb.wr, r_wb.ld};
`else
    logic w_hit1_wb;
    logic w_hit2_wb;
    assign w_hit1_wb = slot_hit(r_wb, rs1_iss, uses_rs1_iss, valid_iss);
    assign w_hit2_wb = slot_hit(r_wb, rs2_iss, uses_rs2_iss, valid_iss);
    // Without bypass paths the consumer waits until the producer has left WB.
    assign w_hazard = w_run && (w_hit1_ex || w_hit2_ex || w_hit1_mem || w_hit2_mem
                                || w_hit1_wb || w_hit2_wb);
    assign w_unused = ^{r_wb.ld, is_load_iss, r_mem.ld};
`endif

    assign w_bubble    = !w_run || w_hazard || w_flush;
    assign stall_fetch = !w_run || (w_hazard && !w_flush);
    assign stall_iss   = !w_run || (w_hazard && !w_flush);
    assign bubble_ex   = w_bubble;
    assign flush_iss   = w_flush;

    assign instr_retired = r_wb.vld;
    assign retire_count  = r_retire_count;
    assign w_retire_nxt  = r_retire_count + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
            r_hold  <= HW'(BOOT_HOLD);
        end else begin
            case (r_state)
                BOOT: begin
                    if (r_hold == '0 || r_hold == HW'(1)) begin
                        r_state <= RUN;
                    end
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HW'(1);
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex           <= '0;
            r_mem          <= '0;
            r_wb           <= '0;
            r_retire_count <= 32'd0;
        end else begin
            r_ex  <= '{vld: valid_iss && !w_bubble, rd: rd_iss, wr: wr_rd_iss, ld: is_load_iss};
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (r_wb.vld) begin
                r_retire_count <= w_retire_nxt;
            end
        end
    end

`ifdef PIPE_FORWARD_EN
    logic [1:0] r_fwd1;
    logic [1:0] r_fwd2;

    // After a load-use stall the load has reached MEM, so the MEM match yields 10 naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fwd1 <= 2'b00;
            r_fwd2 <= 2'b00;
        end else if (w_bubble) begin
            r_fwd1 <= 2'b00;
            r_fwd2 <= 2'b00;
        end else begin
            r_fwd1 <= w_hit1_ex ? 2'b01 : (w_hit1_mem ? 2'b10 : 2'b00);
            r_fwd2 <= w_hit2_ex ? 2'b01 : (w_hit2_mem ? 2'b10 : 2'b00);
        end
    end

    assign fwd_rs1_sel = r_fwd1;
    assign fwd_rs2_sel = r_fwd2;
`else
    logic w_unused_hits;
    assign w_unused_hits = ^{w_unused, r_ex.ld};
    assign fwd_rs1_sel = 2'b00;
    assign fwd_rs2_sel = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: boot hold, RAW/load-use handling, flush priority, x0, counter wrap, mid-run reset.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_iss;
    logic [4:0]  rs1_iss;
    logic [4:0]  rs2_iss;
    logic        uses_rs1_iss;
    logic        uses_rs2_iss;
    logic [4:0]  rd_iss;
    logic        wr_rd_iss;
    logic        is_load_iss;
    logic        branch_taken_ex;
    logic        stall_fetch;
    logic        stall_iss;
    logic        bubble_ex;
    logic        flush_iss;
    logic [1:0]  fwd_rs1_sel;
    logic [1:0]  fwd_rs2_sel;
    logic        instr_retired;
    logic [31:0] retire_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.BOOT_HOLD(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_iss       (valid_iss),
        .rs1_iss         (rs1_iss),
        .rs2_iss         (rs2_iss),
        .uses_rs1_iss    (uses_rs1_iss),
        .uses_rs2_iss    (uses_rs2_iss),
        .rd_iss          (rd_iss),
        .wr_rd_iss       (wr_rd_iss),
        .is_load_iss     (is_load_iss),
        .branch_taken_ex (branch_taken_ex),
        .stall_fetch     (stall_fetch),
        .stall_iss       (stall_iss),
        .bubble_ex       (bubble_ex),
        .flush_iss       (flush_iss),
        .fwd_rs1_sel     (fwd_rs1_sel),
        .fwd_rs2_sel     (fwd_rs2_sel),
        .instr_retired   (instr_retired),
        .retire_count    (retire_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input int v, input int s1, input int u1, input int s2, input int u2,
                         input int d, input int w, input int ld, input int br);
        valid_iss       = 1'(v);
        rs1_iss         = 5'(s1);
        uses_rs1_iss    = 1'(u1);
        rs2_iss         = 5'(s2);
        uses_rs2_iss    = 1'(u2);
        rd_iss          = 5'(d);
        wr_rd_iss       = 1'(w);
        is_load_iss     = 1'(ld);
        branch_taken_ex = 1'(br);
    endtask

    task automatic step(input int v, input int s1, input int u1, input int s2, input int u2,
                        input int d, input int w, input int ld, input int br);
        @(negedge clk);
        drive(v, s1, u1, s2, u2, d, w, ld, br);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stall_fetch"}, 32'(stall_fetch), 32'd1);
        check({tag, "_stall_iss"},   32'(stall_iss),   32'd1);
        check({tag, "_bubble"},      32'(bubble_ex),   32'd1);
        check({tag, "_flush"},       32'(flush_iss),   32'd0);
        check({tag, "_fwd1"},        32'(fwd_rs1_sel), 32'd0);
        check({tag, "_fwd2"},        32'(fwd_rs2_sel), 32'd0);
        check({tag, "_retired"},     32'(instr_retired), 32'd0);
        check({tag, "_count"},       retire_count,     32'd0);
    endtask

    // Release reset and expect exactly four held cycles before RUN.
    task automatic boot_check(input string tag);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 3, 1, 4, 1, 9, 1, 0, 1);
        #1;
        check({tag, "_boot0_stall"}, 32'(stall_fetch), 32'd1);
        check({tag, "_boot0_flush"}, 32'(flush_iss), 32'd0);
        for (int i = 1; i < 4; i++) begin
            idle();
            check({tag, "_boot_stall"},  32'(stall_iss), 32'd1);
            check({tag, "_boot_bubble"}, 32'(bubble_ex), 32'd1);
        end
        idle();
        check({tag, "_run_stall"},  32'(stall_fetch), 32'd0);
        check({tag, "_run_bubble"}, 32'(bubble_ex), 32'd0);
        check({tag, "_run_count"},  retire_count, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef PIPE_FORWARD_EN
        int base = 5;
`else
        int base = 2;
`endif
        reset = 1'b0;
        drive(1, 5, 1, 6, 1, 7, 1, 1, 1);
        #1;
        check_reset_vals("rst");
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("rst_clk");

        boot_check("b1");

`ifdef PIPE_FORWARD_EN
        step(1, 1, 1, 2, 1, 5, 1, 0, 0);            // add x5,x1,x2
        check("raw_add_stall", 32'(stall_fetch), 32'd0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0);            // sub x6,x5,x1
        check("raw_sub_stall", 32'(stall_fetch), 32'd0);
        check("raw_sub_bubble", 32'(bubble_ex), 32'd0);
        step(1, 5, 1, 0, 1, 9, 1, 0, 0);            // or x9,x5,x0
        check("raw_ex_fwd1", 32'(fwd_rs1_sel), 32'd1);
        check("raw_ex_fwd2", 32'(fwd_rs2_sel), 32'd0);
        check("raw_or_stall", 32'(stall_fetch), 32'd0);
        idle();
        check("raw_mem_fwd1", 32'(fwd_rs1_sel), 32'd2);
        check("raw_mem_fwd2", 32'(fwd_rs2_sel), 32'd0);
        check("raw_retired", 32'(instr_retired), 32'd1);
        step(1, 1, 1, 0, 0, 7, 1, 1, 0);            // lw x7
        check("lu_pre_fwd1", 32'(fwd_rs1_sel), 32'd0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0);            // add x8,x7,x7
        check("lu_stall_fetch", 32'(stall_fetch), 32'd1);
        check("lu_stall_iss", 32'(stall_iss), 32'd1);
        check("lu_bubble", 32'(bubble_ex), 32'd1);
        check("lu_flush", 32'(flush_iss), 32'd0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0);
        check("lu_one_stall", 32'(stall_fetch), 32'd0);
        check("lu_one_bubble", 32'(bubble_ex), 32'd0);
        check("lu_bubble_fwd1", 32'(fwd_rs1_sel), 32'd0);
        idle();
        check("lu_fwd1", 32'(fwd_rs1_sel), 32'd2);
        check("lu_fwd2", 32'(fwd_rs2_sel), 32'd2);
        repeat (3) idle();
`else
        step(1, 1, 1, 2, 1, 5, 1, 0, 0);            // add x5,x1,x2
        check("nf_add_stall", 32'(stall_fetch), 32'd0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0);            // sub x6,x5,x1 vs EX
        check("nf_stall_ex", 32'(stall_fetch), 32'd1);
        check("nf_bubble_ex", 32'(bubble_ex), 32'd1);
        check("nf_fwd_ex", 32'(fwd_rs1_sel), 32'd0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0);            // vs MEM
        check("nf_stall_mem", 32'(stall_iss), 32'd1);
        check("nf_fwd_mem", 32'(fwd_rs1_sel), 32'd0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0);            // vs WB
        check("nf_stall_wb", 32'(stall_fetch), 32'd1);
        check("nf_retired", 32'(instr_retired), 32'd1);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0);
        check("nf_release", 32'(stall_fetch), 32'd0);
        idle();
        check("nf_sub_fwd1", 32'(fwd_rs1_sel), 32'd0);
        check("nf_sub_fwd2", 32'(fwd_rs2_sel), 32'd0);
        repeat (3) idle();
`endif
        check("base_count", retire_count, 32'(base));

        step(1, 1, 1, 0, 0, 7, 1, 1, 0);            // lw x7
        step(1, 7, 1, 0, 1, 8, 1, 0, 1);            // add x8,x7,x0 with taken branch
        check("fl_flush", 32'(flush_iss), 32'd1);
        check("fl_stall_fetch", 32'(stall_fetch), 32'd0);
        check("fl_stall_iss", 32'(stall_iss), 32'd0);
        check("fl_bubble", 32'(bubble_ex), 32'd1);
        step(1, 1, 1, 2, 1, 11, 1, 0, 0);           // add x11,x1,x2
        check("fl_no_stall", 32'(stall_fetch), 32'd0);
        check("fl_flush_off", 32'(flush_iss), 32'd0);
        check("fl_fwd1", 32'(fwd_rs1_sel), 32'd0);
        idle();
        check("fl_lw_retire", 32'(instr_retired), 32'd1);
        idle();
        check("fl_slot_empty", 32'(instr_retired), 32'd0);
        idle();
        check("fl_add_retire", 32'(instr_retired), 32'd1);
        idle();
        check("fl_count", retire_count, 32'(base + 2));

        step(1, 1, 1, 2, 1, 0, 1, 0, 0);            // add x0,x1,x2
        check("x0_wr_stall", 32'(stall_fetch), 32'd0);
        step(1, 0, 1, 0, 1, 3, 1, 0, 0);            // sub x3,x0,x0
        check("x0_rd_stall", 32'(stall_fetch), 32'd0);
        check("x0_rd_bubble", 32'(bubble_ex), 32'd0);
        idle();
        check("x0_fwd1", 32'(fwd_rs1_sel), 32'd0);
        check("x0_fwd2", 32'(fwd_rs2_sel), 32'd0);
        idle();
        check("cnt_pre_retired", 32'(instr_retired), 32'd1);
        force dut.w_retire_nxt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.w_retire_nxt;
        idle();
        check("cnt_preset", retire_count, 32'hFFFF_FFFF);
        check("cnt_retired", 32'(instr_retired), 32'd1);
        idle();
        check("cnt_wrap", retire_count, 32'd0);

        step(1, 1, 1, 2, 1, 13, 1, 0, 0);           // add x13
        step(1, 1, 1, 2, 1, 14, 1, 0, 0);           // add x14
        idle();
        step(1, 1, 1, 0, 0, 7, 1, 1, 0);            // lw x7
        step(1, 7, 1, 7, 1, 8, 1, 0, 0);            // add x8,x7,x7
        check("mr_stall", 32'(stall_fetch), 32'd1);
        check("mr_retired", 32'(instr_retired), 32'd1);
        check("mr_count", retire_count, 32'd1);
        #1;
        reset = 1'b0;
        branch_taken_ex = 1'b1;
        #1;
        check_reset_vals("mr_rst");
        repeat (2) @(negedge clk);
        boot_check("b2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
